// File: rtl/cfs_apb_master.sv
// APB requester: single command port to APB SETUP/ACCESS transfers, one transfer in flight.
// Optional ACCESS-phase timeout abort enabled by defining CFS_APB_MASTER_TIMEOUT_EN.
module cfs_apb_master #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int APB_DATA_WIDTH = 32
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_slverr,
    output logic                      rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic                      pready,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;

`ifdef CFS_APB_MASTER_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);

    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    // Counts consecutive ACCESS cycles without pready; the limit-th wait aborts.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ACCESS) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign rsp_timeout        = 1'b0;
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef CFS_APB_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_write ? cmd_wdata : '0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // pready on the limit edge still counts as a normal completion.
                    if (pready) begin
                        state      <= RESP;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= pwrite ? '0 : prdata;
                        rsp_slverr <= pslverr;
`ifdef CFS_APB_MASTER_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
